fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port among P_REQ_NUM requesters. Each requester holds a grant for a burst of up to P_BURST_LEN beats. The block drives the FIFO's write enable and data directly and honours its full flag. It sits between the producer blocks and the FIFO write interface.

## Interface
Parameters:
- P_DATA_WIDTH, 4: data width of each requester and of the FIFO.
- P_REQ_NUM, 4: number of requesters (≥2).
- P_BURST_LEN, 4: maximum beats per grant (≥1).

Ports:
- i_clk, in, 1: single clock; all logic on the rising edge.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_req, in, P_REQ_NUM: per-requester write request; data valid while high.
- i_wdata, in, P_REQ_NUM*P_DATA_WIDTH: requester k data in bits [k*W +: W].
- o_grant, out, P_REQ_NUM: one-hot registered grant; all-zero when idle.
- o_ack, out, P_REQ_NUM: beat accepted this cycle. Only the granted bit can be set.
- o_fifo_wr_en, out, 1: FIFO write enable.
- o_fifo_wdata, out, P_DATA_WIDTH: FIFO write data.
- i_fifo_wfull, in, 1: FIFO full flag.
- o_stat_cnt, out, P_REQ_NUM*16: per-requester accepted-beat counters. Present only with FIFO_ARB_STATS_EN.

## Operation
- Two states:
  - IDLE: no grant held.
  - BUSY: one-hot r_grant held, plus burst counter r_cnt (clog2(P_BURST_LEN)+1 bits).
- IDLE: if any i_req bit is set, choose the first requesting index after r_last, cyclically. Then r_grant ← that one-hot, r_cnt ← 0, go to BUSY. With no request, stay in IDLE.
- BUSY, granted index g:
  - beat = i_req[g] & !i_fifo_wfull.
  - o_fifo_wr_en = beat. o_ack[g] = beat.
  - o_fifo_wdata = slice g of i_wdata.
  - If beat and r_cnt == P_BURST_LEN-1: release.
  - Else if i_req[g] == 0: release.
  - Else if beat: r_cnt += 1.
  - If full: hold the grant; r_cnt is frozen.
- Release: r_grant ← 0, r_last ← g, go to IDLE.
- When no grant is held: o_fifo_wr_en = 0 and o_fifo_wdata = 0. Data is never routed from a non-granted requester.
- Requests from non-granted requesters are ignored until the next IDLE arbitration. Requesters must hold data stable until acked.
- The FIFO is never written while i_fifo_wfull = 1.

## Timing
- Reset values:
  - o_grant = 0, state = IDLE, r_cnt = 0.
  - r_last = P_REQ_NUM-1, so requester 0 wins first.
  - o_ack = 0, o_fifo_wr_en = 0, o_fifo_wdata = 0, o_stat_cnt = 0.
- Arbitration latency: a request seen in IDLE at edge N gives a grant visible after edge N. The first beat can be written in the cycle after that edge.
- o_fifo_wr_en, o_fifo_wdata and o_ack are combinational from r_grant, i_req and i_fifo_wfull. The FIFO captures the data on the same edge.
- Peak throughput: P_BURST_LEN beats followed by one IDLE cycle per grant.
- Full asserted mid-burst: the stall costs zero beats; the grant and count are held.
- Requester drops i_req mid-burst: release on that edge, with no beat that cycle.
- Single requester with a continuous request: it is re-granted after each IDLE cycle.
- i_rst_n asserted mid-burst: all state clears immediately and asynchronously. Beats already written stay in the FIFO.

## Configuration
- FIFO_ARB_STATS_EN defined: per-requester 16-bit counters increment on each o_ack bit. They saturate at 16'hFFFF and are exposed on o_stat_cnt.
- Not defined: o_stat_cnt port and counters are absent. Arbitration behaviour is identical in both builds.

## Structure
- Shared package fifo_arb_pkg holds:
  - the clogb2 function;
  - state encoding constants (ST_IDLE = 1'b0, ST_BUSY = 1'b1);
  - stat counter width (16).
- One sub-module, rr_pick: combinational round-robin selector taking request vector and last-winner index, returning a one-hot pick and a valid flag.

## Test plan
- Reset, then i_req = 4'b0001, 6 beats, full = 0:
  - grant 0001 one cycle after request;
  - 4 beats written;
  - 1 IDLE cycle;
  - re-grant, remaining 2 beats written;
  - data order preserved.
- i_req = 4'b1111 held, full = 0: grants go 0001, 0010, 0100, 1000, 0001, each for 4 beats with one-cycle gaps.
- Requester 2 granted, full pulses high for 3 cycles after beat 1: no writes during the full cycles; burst completes with exactly 4 beats and no acks while full.
- Requester 1 granted, drops i_req after 2 beats while requester 3 requests: requester 1 released after 2 beats; requester 3 granted next.
- Reset asserted in the middle of a 4-beat burst:
  - o_grant, o_fifo_wr_en and o_ack go to 0 immediately;
  - after release, requester 0 wins first.
- FIFO_ARB_STATS_EN build: 10 beats from requester 0 and 3 from requester 2 → o_stat_cnt slices 0 and 2 read 10 and 3, others 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding,
// statistics counter width and the ceiling-log2 helper used for sizing.
package fifo_arb_pkg;

    localparam int STAT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Ceiling log2, so clogb2(4) == 2 and clogb2(1) == 0
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requesting index
// after last_idx (cyclic) as both a one-hot vector and a binary index.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int P_N     = 4,
    parameter int P_IDX_W = clogb2(P_N)
) (
    input  logic [P_N-1:0]     req,
    input  logic [P_IDX_W-1:0] last_idx,
    output logic [P_N-1:0]     pick,
    output logic [P_IDX_W-1:0] pick_idx,
    output logic               valid
);

    // Scan from the farthest candidate to the nearest so the nearest requester overwrites
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int off = P_N; off >= 1; off--) begin
            idx = (int'(last_idx) + off) % P_N;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                pick_idx  = P_IDX_W'(idx);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port among
// P_REQ_NUM requesters, each holding a grant for up to P_BURST_LEN beats.
// Optional per-requester accepted-beat counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int P_DATA_WIDTH = 4,
    parameter int P_REQ_NUM    = 4,
    parameter int P_BURST_LEN  = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [P_REQ_NUM-1:0]              i_req,
    input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_wdata,
    output logic [P_REQ_NUM-1:0]              o_grant,
    output logic [P_REQ_NUM-1:0]              o_ack,
    output logic                              o_fifo_wr_en,
    output logic [P_DATA_WIDTH-1:0]           o_fifo_wdata,
    input  logic                              i_fifo_wfull
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [P_REQ_NUM*STAT_W-1:0]       o_stat_cnt
`endif
);

    localparam int IDX_W = clogb2(P_REQ_NUM);
    localparam int CNT_W = clogb2(P_BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_BURST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_REQ_NUM - 1);

    state_t               r_state, nxt_state;
    logic [P_REQ_NUM-1:0] r_grant, nxt_grant;
    logic [IDX_W-1:0]     r_gidx, nxt_gidx;
    logic [IDX_W-1:0]     r_last, nxt_last;
    logic [CNT_W-1:0]     r_cnt, nxt_cnt;

    logic [P_REQ_NUM-1:0] pick;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 granted_req;
    logic                 beat;

    rr_pick #(
        .P_N     (P_REQ_NUM),
        .P_IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (i_req),
        .last_idx (r_last),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Beat qualification and FIFO write-side datapath, routed only from the granted requester
    always_comb begin
        granted_req  = i_req[r_gidx];
        beat         = (r_state == ST_BUSY) && granted_req && !i_fifo_wfull;
        o_fifo_wr_en = beat;
        o_ack        = beat ? r_grant : '0;
        o_fifo_wdata = '0;
        if (r_state == ST_BUSY) begin
            o_fifo_wdata = i_wdata[r_gidx*P_DATA_WIDTH +: P_DATA_WIDTH];
        end
    end

    assign o_grant = r_grant;

    // Next-state logic: arbitrate in IDLE, count beats and decide release in BUSY
    always_comb begin
        nxt_state = r_state;
        nxt_grant = r_grant;
        nxt_gidx  = r_gidx;
        nxt_last  = r_last;
        nxt_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (pick_valid) begin
                    nxt_state = ST_BUSY;
                    nxt_grant = pick;
                    nxt_gidx  = pick_idx;
                    nxt_cnt   = '0;
                end
            end
            ST_BUSY: begin
                if ((beat && (r_cnt == CNT_LAST)) || !granted_req) begin
                    nxt_state = ST_IDLE;
                    nxt_grant = '0;
                    nxt_last  = r_gidx;
                    nxt_cnt   = '0;
                end else if (beat) begin
                    nxt_cnt = r_cnt + 1'b1;
                end
                // A full FIFO leaves grant and count untouched
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_grant = '0;
            end
        endcase
    end

    // State register; reset makes requester 0 the first winner
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IDX_LAST;
            r_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= nxt_state;
            r_grant <= nxt_grant;
            r_gidx  <= nxt_gidx;
            r_last  <= nxt_last;
            r_cnt   <= nxt_cnt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] r_stat [P_REQ_NUM];

    // Saturating accepted-beat counter per requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: this counter array is a handful of flops, not RAM, so it is reset like any register.
            for (int k = 0; k < P_REQ_NUM; k++) begin
                r_stat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < P_REQ_NUM; k++) begin
                if (o_ack[k] && (r_stat[k] != STAT_MAX)) begin
                    r_stat[k] <= r_stat[k] + 1'b1;
                end
            end
        end
    end

    // Pack the counters onto the flat statistics port
    always_comb begin
        o_stat_cnt = '0;
        for (int k = 0; k < P_REQ_NUM; k++) begin
            o_stat_cnt[k*STAT_W +: STAT_W] = r_stat[k];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random
// phase, all compared cycle by cycle against a behavioural model of the
// arbitration rules and a FIFO-content scoreboard.
module tb_fifo_wr_arbiter;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int BL = 4;

    logic           i_clk;
    logic           i_rst_n;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_wdata;
    logic [N-1:0]   o_grant;
    logic [N-1:0]   o_ack;
    logic           o_fifo_wr_en;
    logic [W-1:0]   o_fifo_wdata;
    logic           i_fifo_wfull;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] o_stat_cnt;
`endif

    fifo_wr_arbiter #(
        .P_DATA_WIDTH (W),
        .P_REQ_NUM    (N),
        .P_BURST_LEN  (BL)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_wdata      (i_wdata),
        .o_grant      (o_grant),
        .o_ack        (o_ack),
        .o_fifo_wr_en (o_fifo_wr_en),
        .o_fifo_wdata (o_fifo_wdata),
        .i_fifo_wfull (i_fifo_wfull)
`ifdef FIFO_ARB_STATS_EN
        ,
        .o_stat_cnt   (o_stat_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: who holds the grant, beats in this grant, last winner
    int holder;
    int cnt;
    int last;
    int seq   [N];
    int beats [N];
    int stat  [N];
    int cycles = 0;
    logic [W-1:0] dut_q [$];
    logic [W-1:0] ref_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        holder = -1;
        cnt    = 0;
        last   = N - 1;
        for (int k = 0; k < N; k++) stat[k] = 0;
    endtask

    function automatic logic [W-1:0] data_of(input int k);
        return W'(seq[k] + 4 * k);
    endfunction

    // One clock cycle: drive at negedge, compare outputs, then advance the model
    task automatic step(input logic [N-1:0] req, input logic full);
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ack;
        logic [W-1:0] e_data;
        logic         beat;
        bit           found;
        @(negedge i_clk);
        i_req        = req;
        i_fifo_wfull = full;
        for (int k = 0; k < N; k++) i_wdata[k*W +: W] = data_of(k);
        #1;
        e_grant = '0;
        e_ack   = '0;
        e_data  = '0;
        beat    = 1'b0;
        if (holder >= 0) begin
            e_grant[holder] = 1'b1;
            beat            = req[holder] && !full;
            e_data          = data_of(holder);
            if (beat) e_ack[holder] = 1'b1;
        end
        check("grant", o_grant, e_grant);
        check("ack", o_ack, e_ack);
        check("wr_en", o_fifo_wr_en, beat);
        check("wdata", o_fifo_wdata, e_data);
        if (o_fifo_wr_en) dut_q.push_back(o_fifo_wdata);
        if (beat) ref_q.push_back(e_data);
        if (holder < 0) begin
            found = 0;
            for (int off = 1; off <= N; off++) begin
                if (!found && req[(last + off) % N]) begin
                    holder = (last + off) % N;
                    cnt    = 0;
                    found  = 1;
                end
            end
        end else begin
            if (beat) begin
                beats[holder]++;
                stat[holder]++;
                seq[holder]++;
            end
            if ((beat && cnt == BL - 1) || !req[holder]) begin
                last   = holder;
                holder = -1;
            end else if (beat) begin
                cnt++;
            end
        end
        cycles++;
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst_n      = 1'b0;
        i_req        = '0;
        i_fifo_wfull = 1'b0;
        model_reset();
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
    endtask

    initial begin
        int b0;
        int c0;
        int guard;
        logic [N-1:0] g;
        logic [N-1:0] prev;
        logic [N-1:0] gseq [$];
        logic [N-1:0] gexp [5];

        for (int k = 0; k < N; k++) begin
            seq[k]   = 0;
            beats[k] = 0;
        end
        model_reset();
        i_rst_n      = 1'b0;
        i_req        = '0;
        i_wdata      = '0;
        i_fifo_wfull = 1'b0;
        #1;
        check("rst_grant", o_grant, 0);
        check("rst_ack", o_ack, 0);
        check("rst_wr_en", o_fifo_wr_en, 0);
        check("rst_wdata", o_fifo_wdata, 0);
`ifdef FIFO_ARB_STATS_EN
        check("rst_stat", o_stat_cnt, 0);
`endif
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;

        // Single requester, 6 beats: burst of 4, one idle cycle, burst of 2
        b0 = beats[0]; c0 = cycles; guard = 0;
        while (beats[0] - b0 < 6 && guard < 40) begin
            step(4'b0001, 1'b0);
            guard++;
        end
        check("t1_beats", beats[0] - b0, 6);
        check("t1_cycles", cycles - c0, 8);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // All requesting: grant order rotates through every requester
        apply_reset();
        prev = '0;
        for (int i = 0; i < 25; i++) begin
            step(4'b1111, 1'b0);
            g = o_grant;
            if (g != 0 && prev == 0) gseq.push_back(g);
            prev = g;
        end
        gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check("t2_ngrants", gseq.size(), 5);
        for (int i = 0; i < 5 && i < gseq.size(); i++) check("t2_order", gseq[i], gexp[i]);
        step(4'b0000, 1'b0);

        // Requester 2 stalled by full after its first beat
        apply_reset();
        b0 = beats[2];
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1);
        check("t3_beats_stall", beats[2] - b0, 1);
        guard = 0;
        while (beats[2] - b0 < 4 && guard < 20) begin
            step(4'b0100, 1'b0);
            guard++;
        end
        check("t3_beats", beats[2] - b0, 4);
        check("t3_resume_cycles", guard, 3);
        step(4'b0100, 1'b0);
        check("t3_released", o_grant, 0);
        step(4'b0000, 1'b0);

        // Requester 1 drops after 2 beats; requester 3 takes over
        apply_reset();
        b0 = beats[1];
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        check("t4_beats1", beats[1] - b0, 2);
        check("t4_grant3", o_grant, 4'b1000);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Reset in the middle of a burst clears outputs immediately
        apply_reset();
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        @(negedge i_clk);
        #1 check("t5_pre_wr", o_fifo_wr_en, 1);
        #1 i_rst_n = 1'b0;
        #1;
        check("t5_grant", o_grant, 0);
        check("t5_wr_en", o_fifo_wr_en, 0);
        check("t5_ack", o_ack, 0);
        model_reset();
        #3 i_rst_n = 1'b1;
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check("t5_first", o_grant, 4'b0001);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Random requests and full flag against the model
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            r = '0;
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 3) != 0);
            step(r, ($urandom_range(0, 3) == 0));
        end
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // Statistics scenario: 10 beats from requester 0, 3 from requester 2
        apply_reset();
        b0 = beats[0]; guard = 0;
        while (beats[0] - b0 < 10 && guard < 40) begin
            step(4'b0001, 1'b0);
            guard++;
        end
        step(4'b0000, 1'b0);
        b0 = beats[2]; guard = 0;
        while (beats[2] - b0 < 3 && guard < 20) begin
            step(4'b0100, 1'b0);
            guard++;
        end
        step(4'b0000, 1'b0);
        check("t6_model0", stat[0], 10);
        check("t6_model2", stat[2], 3);
`ifdef FIFO_ARB_STATS_EN
        check("t6_stat0", o_stat_cnt[0*16 +: 16], 10);
        check("t6_stat1", o_stat_cnt[1*16 +: 16], 0);
        check("t6_stat2", o_stat_cnt[2*16 +: 16], 3);
        check("t6_stat3", o_stat_cnt[3*16 +: 16], 0);
`endif

        // Everything the FIFO received, in order
        check("fifo_len", dut_q.size(), ref_q.size());
        for (int i = 0; i < dut_q.size() && i < ref_q.size(); i++) begin
            check("fifo_data", dut_q[i], ref_q[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
